// File: rtl/ysyx_22050133_shift_divider.sv
// Radix-2 restoring divider for RV64M DIV/REM and their 32-bit W forms.
// One quotient bit per cycle on operand magnitudes; signs fixed up at the end.
module ysyx_22050133_shift_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        div_valid,
    input  logic        divw,
    input  logic        div_signed,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        div_ready,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] shq_q, shq_d;
    logic [63:0] dvs_q, dvs_d;
    logic        w32_q, w32_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    logic        accept;
    logic [63:0] op_a, op_b;
    logic        a_neg, b_neg;
    logic [63:0] mag_a, mag_b;
    logic        b_zero, ovf;
    logic [64:0] part, trial;
    logic        fits;
    logic [63:0] acc_n, shq_n;
    logic [63:0] q_sgn, r_sgn;
    logic [63:0] q_fin, r_fin;

    assign div_ready = (state_q != CALC);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign accept    = div_valid & div_ready & ~flush;

    // Operand preparation: width extension, magnitudes and fast-path detection
    always_comb begin
        if (divw) begin
            op_a = div_signed ? sext32(dividend[31:0]) : {32'b0, dividend[31:0]};
            op_b = div_signed ? sext32(divisor[31:0])  : {32'b0, divisor[31:0]};
        end else begin
            op_a = dividend;
            op_b = divisor;
        end
        a_neg  = div_signed & op_a[63];
        b_neg  = div_signed & op_b[63];
        mag_a  = a_neg ? (~op_a + 64'd1) : op_a;
        mag_b  = b_neg ? (~op_b + 64'd1) : op_b;
        b_zero = divw ? (divisor[31:0] == 32'd0) : (divisor == 64'd0);
        if (divw) begin
            ovf = div_signed
                & (dividend[31:0] == 32'h8000_0000)
                & (divisor[31:0] == 32'hFFFF_FFFF);
        end else begin
            ovf = div_signed
                & (dividend == 64'h8000_0000_0000_0000)
                & (divisor == 64'hFFFF_FFFF_FFFF_FFFF);
        end
    end

    // One restoring step plus sign fix-up of the would-be final result
    always_comb begin
        part  = {acc_q, shq_q[63]};
        trial = part - {1'b0, dvs_q};
        fits  = ~trial[64];
        acc_n = fits ? trial[63:0] : part[63:0];
        shq_n = {shq_q[62:0], fits};
        q_sgn = negq_q ? (~shq_n + 64'd1) : shq_n;
        r_sgn = negr_q ? (~acc_n + 64'd1) : acc_n;
        q_fin = w32_q ? sext32(q_sgn[31:0]) : q_sgn;
        r_fin = w32_q ? sext32(r_sgn[31:0]) : r_sgn;
    end

    // Next-state logic for the IDLE/CALC/DONE controller and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shq_d   = shq_q;
        dvs_d   = dvs_q;
        w32_d   = w32_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (b_zero) begin
                        quo_d   = 64'hFFFF_FFFF_FFFF_FFFF;
                        rem_d   = divw ? sext32(dividend[31:0]) : dividend;
                        state_d = DONE;
                    end else if (ovf) begin
                        quo_d   = divw ? sext32(dividend[31:0]) : dividend;
                        rem_d   = 64'd0;
                        state_d = DONE;
                    end else begin
                        acc_d   = 64'd0;
                        shq_d   = divw ? {mag_a[31:0], 32'b0} : mag_a;
                        dvs_d   = mag_b;
                        cnt_d   = divw ? 7'd32 : 7'd64;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        w32_d   = divw;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_n;
                    shq_d = shq_n;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        quo_d   = q_fin;
                        rem_d   = r_fin;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            acc_q   <= 64'd0;
            shq_q   <= 64'd0;
            dvs_q   <= 64'd0;
            w32_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quo_q   <= 64'd0;
            rem_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shq_q   <= shq_d;
            dvs_q   <= dvs_d;
            w32_q   <= w32_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_shift_divider.sv
// Randomised self-checking bench for the shift divider.
// Expected results come from native SV division plus the RISC-V corner rules.
module tb_ysyx_22050133_shift_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        div_valid;
    logic        divw;
    logic        div_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    ysyx_22050133_shift_divider dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .div_valid (div_valid),
        .divw      (divw),
        .div_signed(div_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_ready (div_ready),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          due;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_q = 64'd0;
    logic [63:0] last_r = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RISC-V M-extension semantics from plain arithmetic
    task automatic model(input logic w, input logic s,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output int lat);
        logic [31:0] a32, b32, q32, r32;
        int          sa, sb;
        longint      la, lb;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            lat = 33;
            if (b32 == 32'd0) begin
                q = '1; r = sx(a32); lat = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q = sx(a32); r = 64'd0; lat = 1;
            end else if (s) begin
                sa = a32; sb = b32;
                q32 = sa / sb; r32 = sa % sb;
                q = sx(q32); r = sx(r32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
                q = sx(q32); r = sx(r32);
            end
        end else begin
            lat = 65;
            if (b == 64'd0) begin
                q = '1; r = a; lat = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'd0; lat = 1;
            end else if (s) begin
                la = a; lb = b;
                q = la / lb; r = la % lb;
            end else begin
                q = a / b; r = a % b;
            end
        end
    endtask

    // Compare process: every low phase, results or held values are checked
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = expq.pop_front();
                    chk("latency", 64'(cyc), 64'(mon_e.due));
                    chk("quotient", quotient, mon_e.q);
                    chk("remainder", remainder, mon_e.r);
                    chk("ready_in_done", {63'd0, div_ready}, 64'd1);
                    last_q = mon_e.q;
                    last_r = mon_e.r;
                end
            end else begin
                chk("hold_quotient", quotient, last_q);
                chk("hold_remainder", remainder, last_r);
                if (expq.size() > 0 && cyc > expq[0].due) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_out_valid: got 0 expected 1 (cycle %0d)", cyc);
                    void'(expq.pop_front());
                end
            end
        end
    end

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(1, 20));
            5: return {$urandom, $urandom} >> $urandom_range(0, 63);
            6: return 64'($urandom);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Present one request during the current low phase; it is accepted at the next edge
    task automatic issue(input logic w, input logic s,
                         input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   lat;
        model(w, s, a, b, e.q, e.r, lat);
        e.due = cyc + lat;
        expq.push_back(e);
        divw       = w;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        div_valid  = 1'b1;
        @(negedge clk);
        #1;
        div_valid = 1'b0;
    endtask

    // Wait for the outstanding result while hammering ignored inputs
    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (expq.size() == 0) return;
            if (!div_ready) begin
                div_valid  = 1'($urandom);
                divw       = 1'($urandom);
                div_signed = 1'($urandom);
                dividend   = rnd_op();
                divisor    = rnd_op();
            end else begin
                div_valid = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        div_valid = 1'b0;
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: got busy expected done (cycle %0d)", cyc);
            expq.delete();
        end
    endtask

    logic [63:0] mq, mr;
    int          ml;

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        div_valid  = 1'b0;
        divw       = 1'b0;
        div_signed = 1'b0;
        dividend   = 64'd0;
        divisor    = 64'd0;

        model(1'b0, 1'b1, -64'sd7, 64'd2, mq, mr, ml);
        chk("model_div_q", mq, -64'sd3);
        chk("model_div_r", mr, -64'sd1);
        chk("model_div_lat", 64'(ml), 64'd65);
        model(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, mq, mr, ml);
        chk("model_divuw_q", mq, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_divuw_lat", 64'(ml), 64'd33);
        model(1'b0, 1'b0, 64'd100, 64'd0, mq, mr, ml);
        chk("model_dz_q", mq, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_dz_r", mr, 64'd100);
        model(1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, mq, mr, ml);
        chk("model_ovf_q", mq, 64'hFFFF_FFFF_8000_0000);
        chk("model_ovf_lat", 64'(ml), 64'd1);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        chk("reset_ready", {63'd0, div_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);

        // First accept on the very first edge after reset release
        #1;
        rst = 1'b0;
        issue(1'b0, 1'b1, -64'sd7, 64'd2);
        wait_done();
        // Back-to-back accepts in DONE
        issue(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1);
        wait_done();
        issue(1'b0, 1'b0, 64'd100, 64'd0);
        wait_done();
        issue(1'b1, 1'b1, 64'h0000_0000_8000_0000, '1);
        wait_done();
        issue(1'b0, 1'b0, 64'd1000, 64'd7);
        wait_done();

        // Flush in cycle 10 of a 64-bit op
        begin
            int c0;
            c0 = cyc;
            issue(1'b0, 1'b0, 64'hDEAD_BEEF_1234_5678, 64'd13);
            while (cyc < c0 + 10) begin
                @(negedge clk);
                #1;
            end
            flush = 1'b1;
            expq.delete();
            @(negedge clk);
            #1;
            flush = 1'b0;
            chk("flush_ready", {63'd0, div_ready}, 64'd1);
            chk("flush_no_valid", {63'd0, out_valid}, 64'd0);
            repeat (70) @(negedge clk);
            #1;
        end

        // Flush together with a request in IDLE must not accept it
        divw = 1'b0; div_signed = 1'b0;
        dividend = 64'd55; divisor = 64'd5;
        div_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        #1;
        div_valid = 1'b0;
        flush = 1'b0;
        chk("flush_blocks_accept", {63'd0, div_ready}, 64'd1);
        chk("flush_blocks_valid", {63'd0, out_valid}, 64'd0);
        repeat (3) @(negedge clk);
        #1;

        // Asynchronous reset in the middle of CALC
        issue(1'b0, 1'b1, 64'd12345, 64'd3);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_quotient", quotient, 64'd0);
        chk("async_rst_remainder", remainder, 64'd0);
        chk("async_rst_ready", {63'd0, div_ready}, 64'd1);
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        expq.delete();
        last_q = 64'd0;
        last_r = 64'd0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (70) @(negedge clk);
        #1;

        // Randomised traffic with occasional idle gaps
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                div_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1;
            end
            issue(1'($urandom), 1'($urandom), rnd_op(), rnd_op());
            wait_done();
        end

        div_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_shift_divider.md
YSYX_22050133_SHIFT_DIVIDER -- requirements
Module: ysyx_22050133_shift_divider

Interface
REQ-001 Parameters SHALL be none; the datapath is fixed at XLEN=64.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 flush  input  1  abort in-flight division; highest priority after rst.
REQ-005 div_valid  input  1  request valid; a request is accepted on an edge where div_valid & div_ready & !flush.
REQ-006 divw  input  1  1 = 32-bit op (DIVW/DIVUW/REMW/REMUW); 0 = 64-bit op.
REQ-007 div_signed  input  1  1 = signed operands; 0 = unsigned.
REQ-008 dividend  input  64  dividend; only [31:0] is used when divw=1.
REQ-009 divisor  input  64  divisor; only [31:0] is used when divw=1.
REQ-010 div_ready  output  1  high = able to accept a request.
REQ-011 out_valid  output  1  single-cycle pulse = quotient/remainder valid.
REQ-012 quotient  output  64  final quotient, fully 64-bit, sign-extended for divw.
REQ-013 remainder  output  64  final remainder, fully 64-bit, sign-extended for divw.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
- div_ready=1 in IDLE and DONE.
- div_ready=0 in CALC.
- out_valid=1 only in DONE.
REQ-015 Transitions SHALL be:
- IDLE/DONE + accept -> CALC (normal) or DONE (fast path).
- IDLE/DONE without accept -> IDLE.
- CALC on its last iteration -> DONE.
- Any state with flush=1 -> IDLE.
REQ-016 The algorithm SHALL be radix-2 restoring division on operand magnitudes with one quotient bit per cycle.
- Iteration count N = 64 (divw=0) or 32 (divw=1).
- An iteration counter SHALL be loaded at accept and decremented each cycle in CALC.
REQ-017 Normal latency: accept edge in cycle 0; CALC during cycles 1..N; out_valid=1 during cycle N+1 exactly.
REQ-018 Operand prep for divw=1:
- div_signed=1: sign-extend [31:0] of each operand.
- div_signed=0: zero-extend [31:0] of each operand.
REQ-019 Signed result signs:
- quotient sign = sign(dividend) XOR sign(divisor).
- remainder sign = sign(dividend).
- Negation SHALL be two's complement at the operating width.
REQ-020 For divw=1, the final 32-bit quotient and remainder SHALL be sign-extended from bit 31 into [63:32], including DIVUW/REMUW.
REQ-021 Fast path, divide by zero (divisor at operating width == 0):
- DONE in cycle 1.
- quotient = all ones (64'hFFFF_FFFF_FFFF_FFFF).
- remainder = dividend at operating width, sign-extended for divw.
REQ-022 Fast path, signed overflow (div_signed=1, dividend = most-negative, divisor = -1):
- DONE in cycle 1.
- quotient = dividend (sign-extended for divw).
- remainder = 0.
REQ-023 Divide-by-zero SHALL take precedence over overflow detection.
REQ-024 quotient and remainder SHALL hold their last values until the next DONE entry; they SHALL NOT change on accept or during CALC.
REQ-025 Requests presented while div_ready=0 SHALL be ignored (not queued).
REQ-026 Operands and mode SHALL be captured at accept; input changes during CALC SHALL NOT affect the result.
REQ-027 An accept in DONE (back-to-back) SHALL be legal; out_valid deasserts in the next cycle.
REQ-028 flush=1 together with div_valid in IDLE/DONE SHALL NOT accept the request.
REQ-029 flush during CALC SHALL return to IDLE on the next edge, with no out_valid for the aborted op and quotient/remainder unchanged.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, div_ready=1, out_valid=0, quotient=0, remainder=0, counter=0.
REQ-031 rst asserted mid-CALC SHALL discard the operation; no out_valid follows deassertion.
REQ-032 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 Signed 64-bit: dividend=-7, divisor=2, div_signed=1, divw=0 -> out_valid in cycle 65, quotient=-3, remainder=-1.
REQ-034 Unsigned 32-bit: DIVUW dividend=64'h0000_0000_FFFF_FFFF, divisor=1 -> out_valid in cycle 33, quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=0.
REQ-035 Divide by zero: dividend=100, divisor=0, divw=0 -> out_valid in cycle 1, quotient=all ones, remainder=100.
REQ-036 Signed overflow: DIVW dividend=32'h8000_0000, divisor=-1 -> out_valid in cycle 1, quotient=64'hFFFF_FFFF_8000_0000, remainder=0.
REQ-037 Flush: flush=1 in cycle 10 of a 64-bit op -> div_ready=1 in cycle 11, no out_valid, and the prior quotient/remainder are retained.
REQ-038 Reset: async rst asserted mid-CALC between edges -> outputs go to reset values before the next edge; back-to-back accept in DONE yields a second out_valid N+1 cycles later.
